// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// Shares the spare port of a dual-port RAM between NUM_REQ requesters, for
// example a NoC DMA, a debug loader and a packet-buffer reader. Arbitration
// is round-robin. A requester can hold the port for a locked burst of at
// most MAX_BURST beats. Word addresses at or above SIZE are never written.
// Such accesses return an error pulse instead of read data.
//
// Ports
//   i_clock       system clock
//   i_reset       synchronous reset, active low
//   i_enable      global enable; low = no grants, all state frozen
//   i_req         per-requester request (level)
//   i_req_lock    per-requester burst lock, sampled with i_req
//   i_req_addr    packed word addresses, requester i in slice i
//   i_req_wb      packed byte strobes, all-zero = read
//   i_req_wdata   packed write data
//   o_gnt         one-hot grant, combinational, same cycle as RAM drive
//   o_rvalid      one-hot read-data valid, one cycle after a granted read
//   o_rerr        one-hot out-of-range pulse, same timing as o_rvalid
//   o_rdata       shared read data, qualified by o_rvalid
//   o_mem_addr    RAM word address
//   o_mem_wb      RAM byte write strobes
//   o_mem_wdata   RAM write data
//   i_mem_rdata   RAM read data (one cycle latency)

module ram_port_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int SIZE      = 16384,
  parameter int MAX_BURST = 8
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] i_req_wb,
  input  logic [NUM_REQ*DATA_W-1:0]     i_req_wdata,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rvalid,
  output logic [NUM_REQ-1:0]            o_rerr,
  output logic [DATA_W-1:0]             o_rdata,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [DATA_W/8-1:0]           o_mem_wb,
  output logic [DATA_W-1:0]             o_mem_wdata,
  input  logic [DATA_W-1:0]             i_mem_rdata
);

  localparam int WB_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Unpacked views of the packed request buses
  logic [ADDR_W-1:0] w_addr  [NUM_REQ];
  logic [WB_W-1:0]   w_wb    [NUM_REQ];
  logic [DATA_W-1:0] w_wdata [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi]  = i_req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wb[gi]    = i_req_wb[gi*WB_W +: WB_W];
      assign w_wdata[gi] = i_req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // State
  logic [IDX_W-1:0]  r_ptr;
  logic              r_own_vld;
  logic [IDX_W-1:0]  r_own;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [NUM_REQ-1:0] r_rerr;

  // Arbitration results
  logic              w_found;
  logic [IDX_W-1:0]  w_g;
  logic [IDX_W-1:0]  w_cand;
  logic              w_grant;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [WB_W-1:0]   w_sel_wb;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_oor;
  logic              w_is_read;
  logic [IDX_W-1:0]  w_ptr_next;
  logic [CNT_W-1:0]  w_cnt_new;
  logic              w_own_drop;

  // Winner selection: a lock owner still requesting has priority. Otherwise
  // scan from the pointer upward with wrap, and take the first request.
  always_comb begin
    w_found = 1'b0;
    w_g     = '0;
    w_cand  = '0;
    if (r_own_vld && i_req[r_own]) begin
      w_found = 1'b1;
      w_g     = r_own;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
        if (!w_found && i_req[w_cand]) begin
          w_found = 1'b1;
          w_g     = w_cand;
        end
      end
    end
  end

  // No grant while disabled or while reset is asserted
  assign w_grant = w_found && i_enable && i_reset;

  assign w_sel_addr  = w_addr[w_g];
  assign w_sel_wb    = w_wb[w_g];
  assign w_sel_wdata = w_wdata[w_g];
  assign w_oor       = (33'(w_sel_addr) >= 33'(SIZE));
  assign w_is_read   = (w_sel_wb == '0);

  always_comb begin
    o_gnt = '0;
    if (w_grant) begin
      o_gnt[w_g] = 1'b1;
    end
  end

  // Idle cycles keep presenting the last granted address to the RAM
  assign o_mem_addr  = w_grant ? w_sel_addr : r_addr_hold;
  assign o_mem_wdata = w_sel_wdata;
  // Out-of-range beats are demoted to reads, so the RAM is never written
  assign o_mem_wb    = (w_grant && !w_oor) ? w_sel_wb : '0;

  assign o_rvalid = r_rvalid;
  assign o_rerr   = r_rerr;
  // RAM read latency is one cycle, so data lines up with r_rvalid
  assign o_rdata  = i_mem_rdata;

  assign w_ptr_next = (w_g == IDX_W'(NUM_REQ - 1)) ? '0 : w_g + IDX_W'(1);

  // Continue the count only when this grant extends the current owner's
  // burst. A new locker always starts at one beat.
  assign w_cnt_new = (r_own_vld && (r_own == w_g)) ? r_cnt + CNT_W'(1) : CNT_W'(1);

  // The owner gives up the lock as soon as it drops either req or lock
  assign w_own_drop = r_own_vld && (!i_req[r_own] || !i_req_lock[r_own]);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_ptr       <= '0;
      r_own_vld   <= 1'b0;
      r_own       <= '0;
      r_cnt       <= '0;
      r_addr_hold <= '0;
      r_rvalid    <= '0;
      r_rerr      <= '0;
    end else begin
      r_rvalid <= '0;
      r_rerr   <= '0;
      if (w_grant) begin
        r_addr_hold <= w_sel_addr;
        r_ptr       <= w_ptr_next;
        if (w_oor) begin
          r_rerr[w_g] <= 1'b1;
        end else if (w_is_read) begin
          r_rvalid[w_g] <= 1'b1;
        end
        if (i_req_lock[w_g]) begin
          // When the burst limit is reached, the owner is released. The
          // next cycle is then arbitrated from the advanced pointer.
          if (w_cnt_new >= CNT_W'(MAX_BURST)) begin
            r_own_vld <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_own_vld <= 1'b1;
            r_own     <= w_g;
            r_cnt     <= w_cnt_new;
          end
        end else begin
          r_own_vld <= 1'b0;
          r_cnt     <= '0;
        end
      end else if (i_enable && w_own_drop) begin
        r_own_vld <= 1'b0;
        r_cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter. A small byte-writable RAM model
// with one-cycle read latency sits on the memory port.
// The bench changes inputs 1 ns after each rising edge.
// It samples outputs on the falling edge.

module tb_ram_port_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int SIZE      = 16384;
  localparam int MAX_BURST = 8;
  localparam int WB_W      = DATA_W / 8;
  localparam int RAM_AW    = $clog2(SIZE);

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        enable;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          req_lock;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*WB_W-1:0]     req_wb;
  logic [NUM_REQ*DATA_W-1:0]   req_wdata;
  logic [NUM_REQ-1:0]          gnt;
  logic [NUM_REQ-1:0]          rvalid;
  logic [NUM_REQ-1:0]          rerr;
  logic [DATA_W-1:0]           rdata;
  logic [ADDR_W-1:0]           mem_addr;
  logic [WB_W-1:0]             mem_wb;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SIZE(SIZE), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(enable),
    .i_req(req), .i_req_lock(req_lock), .i_req_addr(req_addr),
    .i_req_wb(req_wb), .i_req_wdata(req_wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rerr(rerr), .o_rdata(rdata),
    .o_mem_addr(mem_addr), .o_mem_wb(mem_wb), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // RAM model with a preload path used only while nothing is granted
  logic [DATA_W-1:0] ram [SIZE];
  logic              pl_en = 1'b0;
  logic [RAM_AW-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else begin
      for (int b = 0; b < WB_W; b++) begin
        if (mem_wb[b]) ram[mem_addr[RAM_AW-1:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    mem_rdata <= ram[mem_addr[RAM_AW-1:0]];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [RAM_AW-1:0] a, input logic [DATA_W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    next_cycle();
    pl_en = 1'b0;
  endtask

  task automatic set_req(input int i, input logic r, input logic l,
                         input logic [ADDR_W-1:0] a, input logic [WB_W-1:0] w,
                         input logic [DATA_W-1:0] d);
    req[i] = r;
    req_lock[i] = l;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wb[i*WB_W +: WB_W] = w;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_reqs();
    req = '0; req_lock = '0; req_addr = '0; req_wb = '0; req_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1;
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    total++; if (mem_wb !== 4'h0) begin bad++; $display("FAIL reset_mem_wb got=%h exp=0", mem_wb); end
    total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
    total++; if (rerr !== 2'b00) begin bad++; $display("FAIL reset_rerr got=%b exp=00", rerr); end
    next_cycle();
    clear_reqs();
    rst_n = 1'b1;
    $display("reset: gnt=%b mem_wb=%h rvalid=%b rerr=%b", gnt, mem_wb, rvalid, rerr);
  endtask

  task automatic test_round_robin();
    logic [1:0]        eg [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [1:0]        ev [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [DATA_W-1:0] ed [5] = '{32'h0, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hA0A0A0A0, 32'hB1B1B1B1};
    preload(RAM_AW'(16'h0020), 32'hA0A0A0A0);
    preload(RAM_AW'(16'h0021), 32'hB1B1B1B1);
    set_req(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 16'h0021, 4'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) clear_reqs();
      @(negedge clk);
      total++; if (gnt !== eg[c]) begin bad++; $display("FAIL rr_gnt c%0d got=%b exp=%b", c, gnt, eg[c]); end
      total++; if (rvalid !== ev[c]) begin bad++; $display("FAIL rr_rvalid c%0d got=%b exp=%b", c, rvalid, ev[c]); end
      if (c > 0) begin
        total++; if (rdata !== ed[c]) begin bad++; $display("FAIL rr_rdata c%0d got=%h exp=%h", c, rdata, ed[c]); end
      end
      $display("round_robin c%0d: gnt=%b rvalid=%b rdata=%h", c, gnt, rvalid, rdata);
      next_cycle();
    end
  endtask

  task automatic test_single_read();
    preload(RAM_AW'(16'h0010), 32'hDEADBEEF);
    set_req(0, 1'b1, 1'b0, 16'h0010, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL read_gnt got=%b exp=01", gnt); end
    total++; if (mem_addr !== 16'h0010) begin bad++; $display("FAIL read_mem_addr got=%h exp=0010", mem_addr); end
    total++; if (mem_wb !== 4'h0) begin bad++; $display("FAIL read_mem_wb got=%h exp=0", mem_wb); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL read_rvalid got=%b exp=01", rvalid); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata got=%h exp=deadbeef", rdata); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL read_idle_gnt got=%b exp=00", gnt); end
    total++; if (mem_addr !== 16'h0010) begin bad++; $display("FAIL read_addr_hold got=%h exp=0010", mem_addr); end
    $display("single_read: rvalid=%b rdata=%h mem_addr=%h", rvalid, rdata, mem_addr);
    next_cycle();
  endtask

  task automatic test_burst();
    logic [1:0] exp_g;
    set_req(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0);
    set_req(1, 1'b1, 1'b1, 16'h0021, 4'h0, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      exp_g = (c == 9) ? 2'b01 : 2'b10;
      @(negedge clk);
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL burst_gnt c%0d got=%b exp=%b", c, gnt, exp_g); end
      if (c == 10) begin
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL burst_rvalid c%0d got=%b exp=01", c, rvalid); end
      end
      $display("burst c%0d: gnt=%b rvalid=%b", c, gnt, rvalid);
      next_cycle();
    end
    clear_reqs();
    @(negedge clk);
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL burst_idle_gnt got=%b exp=00", gnt); end
    next_cycle();
  endtask

  task automatic test_write_merge();
    preload(RAM_AW'(16'h0004), 32'hAABBCCDD);
    set_req(0, 1'b1, 1'b0, 16'h0004, 4'b0011, 32'h11223344);
    @(negedge clk);
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b exp=01", gnt); end
    total++; if (mem_wb !== 4'b0011) begin bad++; $display("FAIL wr_mem_wb got=%b exp=0011", mem_wb); end
    total++; if (mem_wdata !== 32'h11223344) begin bad++; $display("FAIL wr_mem_wdata got=%h exp=11223344", mem_wdata); end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 16'h0004, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid got=%b exp=00", rvalid); end
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_rd_gnt got=%b exp=01", gnt); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL wr_rd_rvalid got=%b exp=01", rvalid); end
    total++; if (rdata !== 32'hAABB3344) begin bad++; $display("FAIL wr_rd_rdata got=%h exp=aabb3344", rdata); end
    total++; if (ram[4] !== 32'hAABB3344) begin bad++; $display("FAIL wr_ram_word got=%h exp=aabb3344", ram[4]); end
    $display("write_merge: rvalid=%b rdata=%h", rvalid, rdata);
    next_cycle();
  endtask

  task automatic test_out_of_range();
    preload(RAM_AW'(0), 32'h12345678);
    set_req(0, 1'b1, 1'b0, 16'h4000, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL oor_gnt got=%b exp=01", gnt); end
    total++; if (mem_wb !== 4'h0) begin bad++; $display("FAIL oor_mem_wb got=%h exp=0", mem_wb); end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    total++; if (rerr !== 2'b01) begin bad++; $display("FAIL oor_rerr got=%b exp=01", rerr); end
    total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL oor_rvalid got=%b exp=00", rvalid); end
    total++; if (ram[0] !== 32'h12345678) begin bad++; $display("FAIL oor_ram_word got=%h exp=12345678", ram[0]); end
    $display("out_of_range: rerr=%b rvalid=%b", rerr, rvalid);
    next_cycle();
  endtask

  task automatic test_enable_reset();
    // Pointer is 1 here, so requester 0 wins only as the lock owner
    set_req(0, 1'b1, 1'b1, 16'h0010, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL er_beat1 got=%b exp=01", gnt); end
    next_cycle();
    set_req(1, 1'b1, 1'b0, 16'h0021, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL er_beat2_owner got=%b exp=01", gnt); end
    next_cycle();
    enable = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'h0010, 4'hF, 32'h55555555);
    @(negedge clk);
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL er_dis_gnt got=%b exp=00", gnt); end
    total++; if (mem_wb !== 4'h0) begin bad++; $display("FAIL er_dis_mem_wb got=%h exp=0", mem_wb); end
    total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL er_dis_rvalid got=%b exp=01", rvalid); end
    next_cycle();
    @(negedge clk);
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL er_dis2_gnt got=%b exp=00", gnt); end
    total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL er_dis2_rvalid got=%b exp=00", rvalid); end
    next_cycle();
    enable = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL er_rst_gnt got=%b exp=00", gnt); end
    total++; if (mem_wb !== 4'h0) begin bad++; $display("FAIL er_rst_mem_wb got=%h exp=0", mem_wb); end
    next_cycle();
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0010, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL er_post_rvalid got=%b exp=00", rvalid); end
    total++; if (rerr !== 2'b00) begin bad++; $display("FAIL er_post_rerr got=%b exp=00", rerr); end
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL er_post_gnt got=%b exp=01", gnt); end
    $display("enable_reset: post-reset gnt=%b rvalid=%b", gnt, rvalid);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL er_final_rvalid got=%b exp=01", rvalid); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_burst();
    test_write_merge();
    test_out_of_range();
    test_enable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the dual-port RAM among NUM_REQ requesters, such as a NoC network-interface DMA, a debug loader and a packet-buffer reader.
- Sits between the requesters and the RAM port that is not used by the core.
- Drives word address, byte write strobes and write data to the RAM port, and returns read data with a valid pulse.
- Supports locked bursts bounded by MAX_BURST, and rejects out-of-range addresses.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 16, word-address width.
- DATA_W, 32, data width; byte strobes are DATA_W/8 wide.
- SIZE, 16384, RAM depth in words; an address >= SIZE is out of range.
- MAX_BURST, 8, maximum consecutive locked grants to one requester.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  global enable; when low, no grants are issued and all state holds.
- req  in  NUM_REQ  per-requester access request, level.
- req_lock  in  NUM_REQ  per-requester burst lock, sampled with req.
- req_addr  in  NUM_REQ*ADDR_W  packed word addresses; requester i occupies slice i.
- req_wb  in  NUM_REQ*DATA_W/8  packed byte strobes; all-zero means read.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the RAM drive.
- rvalid  out  NUM_REQ  one-hot read-data valid, registered.
- rerr  out  NUM_REQ  one-hot out-of-range error pulse, aligned with rvalid timing.
- rdata  out  DATA_W  read data, shared by all requesters; qualify with rvalid.
- mem_addr  out  ADDR_W  to RAM addr_in.
- mem_wb  out  DATA_W/8  to RAM wb_in.
- mem_wdata  out  DATA_W  to RAM data_in.
- mem_rdata  in  DATA_W  from RAM data_out.

Behaviour:
- Reset (reset==0 at posedge):
  - rvalid=0, rerr=0, round-robin pointer=0, lock owner cleared, burst counter=0.
  - gnt=0 and mem_wb=0 while reset is low.
  - A burst in flight is abandoned; no pending rvalid survives reset.
- Arbitration (combinational, evaluated each cycle with enable=1 and reset=1):
  - If a lock owner exists and req[owner]=1, grant the owner.
  - Otherwise, grant the first requester with req=1, searching from the pointer upward and wrapping modulo NUM_REQ.
  - At most one gnt bit is high. gnt=0 when no req is high or enable=0.
- Grant consequence, with requester g granted:
  - mem_addr = req_addr[g], mem_wdata = req_wdata[g], mem_wb = req_wb[g].
  - When nothing is granted: mem_wb=0, and mem_addr holds its last granted value (registered copy).
  - The requester treats gnt as an accepted beat and may change addr/data in the next cycle.
- Pointer update:
  - On every granted cycle, at posedge, pointer <= g+1 mod NUM_REQ.
  - The pointer is unchanged when nothing is granted.
- Lock and burst:
  - If req_lock[g]=1 when granted, owner <= g and burst counter increments.
  - When the counter reaches MAX_BURST, the owner is cleared and the counter is reset to 0. The next cycle is arbitrated normally, so other pending requesters win before g again.
  - Owner is cleared when req[owner] drops or req_lock[owner] drops.
  - A granted beat without lock clears the owner and the counter.
- Read return:
  - A granted read (req_wb[g]==0) sets rvalid[g]=1 at the next posedge, for exactly one cycle.
  - rdata = mem_rdata during that cycle (RAM latency 1).
  - Back-to-back reads give back-to-back rvalid; requesters may alternate cycle by cycle.
  - Writes produce no rvalid. Mixed byte writes pass strobes unchanged.
- Out of range:
  - A granted access with req_addr[g] >= SIZE is forced to mem_wb=0.
  - rerr[g]=1 at the next posedge, with rvalid[g]=0. rdata is don't-care.
  - The grant still counts toward the pointer and the burst counter.
- Enable:
  - enable=0 suppresses gnt and mem_wb and freezes pointer, owner and counter.
  - An rvalid already scheduled from the previous cycle is still delivered.
- Simultaneous events:
  - Requests arriving in the same cycle resolve by pointer order.
  - A lock owner dropping req in the same cycle another requester raises req: the other requester is granted that cycle.

Test Plan:
- Reset, then req[0]=1, read, addr 0x0010, RAM holding 0xDEADBEEF: gnt[0] that cycle, mem_addr=0x0010, mem_wb=0; next cycle rvalid[0]=1, rdata=0xDEADBEEF.
- req=2'b11, both reads, held 4 cycles, pointer 0: gnt sequence 01,10,01,10; rvalid follows one cycle later, same order.
- req[1]=1 with lock held 12 cycles, req[0]=1 throughout, MAX_BURST=8: gnt[1] for 8 cycles, gnt[0] on cycle 9, then gnt[1] resumes.
- req[0] write, addr 0x0004, wb=4'b0011, data 0x11223344, then read: RAM word low half becomes 0x3344, upper bytes unchanged; write produces no rvalid, read returns the merged word with rvalid.
- req[0], addr=SIZE (0x4000), wb=4'hF: mem_wb=0, next cycle rerr[0]=1, rvalid[0]=0, RAM contents unchanged.
- Reset low during the 3rd beat of a locked burst, with enable low for 2 cycles before that: no gnt while enable=0; after reset, gnt=0, rvalid=0, pointer=0, owner cleared; the first request after release is arbitrated from requester 0.
